chunked_serial_adder: RTL and testbench
=======================================

# chunked_serial_adder

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, and carries between chunks through a registered carry. It replaces fixed 4-bit combinational adders where area matters more than latency. A start/busy/done handshake lets a controller issue back-to-back operations, and the block reports carry-out and signed overflow.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 1.
- CHUNK, 4, bits added per cycle; WIDTH % CHUNK must be 0. N = WIDTH/CHUNK is the number of chunk cycles.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state and outputs.
- start  input  1  request a new operation; sampled only while busy = 0.
- sub  input  1  0 selects a + b + cin; 1 selects a − b (a + ~b + 1, with cin ignored).
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in for add mode, captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse indicating the result outputs have just been updated.
- sum  output  WIDTH  result, held stable until the next completion.
- cout  output  1  carry out of bit WIDTH−1. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- **States:** IDLE and BUSY. The done pulse is a registered flag, not a separate state.
- **IDLE with start = 1:**
  - Latch a, the effective B (b if sub = 0, ~b if sub = 1), and the carry (cin if sub = 0, 1 if sub = 1).
  - Clear the chunk counter to 0.
  - Go to BUSY and set busy = 1.
- **BUSY, each edge:**
  - Add chunk k of A, chunk k of effective B, and the carry register: CHUNK+1 bits.
  - Write the low CHUNK bits into result bits [k·CHUNK +: CHUNK].
  - Store the top bit as the new carry.
  - Increment k.
- **Last chunk (k = N−1):**
  - Also capture the carry into bit WIDTH−1 for ovf.
  - Update sum, cout, and ovf.
  - Set done = 1 and busy = 0, and return to IDLE.
- **Stability:** sum, cout, and ovf change only at completion. Partial results are held internally and are never visible on sum.
- **Ignored start:** start while busy = 1 is ignored. Changes to a, b, sub, and cin during BUSY have no effect.
- **Back-to-back:** start = 1 in the done cycle (busy = 0) is accepted. done drops on that edge and busy rises.
- **Degenerate sizes:** CHUNK = WIDTH (N = 1) must complete in one BUSY edge. CHUNK = 1 is fully bit-serial.
- **Reset:**
  - Asserting rst at any time, including mid-operation, immediately forces IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, and all internal registers are cleared.
  - An aborted operation never produces done.

## Timing
- Let E0 be the edge that samples start = 1 in IDLE.
- busy is high in the cycles following E0 through EN.
- Chunk k is processed at edge E(k+1).
- Results and done update at edge EN. done is high for exactly the one cycle between EN and EN+1.
- **Latency:** N edges from acceptance to done. Throughput is one operation per N cycles when back-to-back.
- **Reset values:** all outputs are 0. Reset assertion takes effect without a clock edge. After deassertion, the first start is accepted on the next rising edge.

## Test plan
All cases use WIDTH = 16, CHUNK = 4 (N = 4) unless stated otherwise.
1. Add with carry-in: a=0x1234, b=0x0FFF, cin=1, sub=0 → sum=0x2234, cout=0, ovf=0. done is high exactly one cycle after E4, and busy is high for 4 cycles.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. This checks carry propagation across all chunk boundaries.
3. Subtraction:
   - a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
4. Signed overflow on add: a=0x7FFF, b=0x0001, sub=0, cin=0 → sum=0x8000, cout=0, ovf=1. The previous sum stays unchanged until E4.
5. Handshake:
   - Hold start=1 with changing a/b during BUSY → no effect; only the first result is produced.
   - Assert start in the done cycle with a=0x0001, b=0x0002 → accepted immediately; sum=0x0003 four edges later.
6. Reset and parameter sweep:
   - Assert rst asynchronously between E2 and E3 → all outputs 0 at once and no done. A following op (0x00FF + 0x0001 = 0x0100) is correct.
   - Repeat cases 1–4 at CHUNK=16 (1-cycle latency) and CHUNK=1 (16-cycle latency).

Source files
------------

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : Multi-cycle adder/subtractor. Processes CHUNK bits per clock,
//               least-significant chunk first, through a registered carry.
//               start/busy/done handshake; reports carry-out and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q;       // operand A, shifted right one chunk per cycle
    logic [WIDTH-1:0] b_q;       // effective operand B, shifted likewise
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] part_q;    // partial result, filled from the top down
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] next_part;

    assign accept = (state_q == c_IDLE) && start_i;
    assign last   = (state_q == c_BUSY) && (cnt_q == c_LAST);

    // The low chunk of the shifted operands is always the chunk being processed.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

    generate
        if (N == 1) begin : g_single
            logic unused_part;
            assign unused_part = ^part_q;
            assign next_part   = chunk_sum[CHUNK-1:0];
        end else begin : g_multi
            assign next_part = {chunk_sum[CHUNK-1:0], part_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, leave BUSY after the last chunk
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start_i) state_d = c_BUSY;
            c_BUSY:  if (last)    state_d = c_IDLE;
            default:              state_d = c_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy_o = (state_q == c_BUSY);
    end

    // Datapath: capture operands on accept, add one chunk per busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : cin_i;
            cnt_q   <= '0;
            part_q  <= '0;
        end else if (state_q == c_BUSY) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= chunk_sum[CHUNK];
            part_q  <= next_part;
            cnt_q   <= cnt_q + c_ONE;
            if (last) begin
                sum_q  <= next_part;
                cout_q <= chunk_sum[CHUNK];
                ovf_q  <= msb_cin ^ chunk_sum[CHUNK];
            end
        end
    end

    // Completion pulse, high for the single cycle after the last chunk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last;
        end
    end

    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_serial_adder
// Description : Self-checking bench for chunked_serial_adder at CHUNK = 4, 16
//               and 1 (WIDTH = 16), with a scoreboard of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       start = '0;
    logic             sub_in = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             cin_in = 1'b0;

    logic             busy [3];
    logic             done [3];
    logic [WIDTH-1:0] sum  [3];
    logic             cout [3];
    logic             ovf  [3];

    int total = 0;
    int bad   = 0;

    // Expected {cout, ovf, sum} entries
    logic [WIDTH+1:0] sb_q [$];

    int nchunks [3] = '{4, 1, 16};

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start[0]), .sub_i(sub_in),
        .a_i(a_in), .b_i(b_in), .cin_i(cin_in),
        .busy_o(busy[0]), .done_o(done[0]), .sum_o(sum[0]),
        .cout_o(cout[0]), .ovf_o(ovf[0])
    );

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(start[1]), .sub_i(sub_in),
        .a_i(a_in), .b_i(b_in), .cin_i(cin_in),
        .busy_o(busy[1]), .done_o(done[1]), .sum_o(sum[1]),
        .cout_o(cout[1]), .ovf_o(ovf[1])
    );

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start[2]), .sub_i(sub_in),
        .a_i(a_in), .b_i(b_in), .cin_i(cin_in),
        .busy_o(busy[2]), .done_o(done[2]), .sum_o(sum[2]),
        .cout_o(cout[2]), .ovf_o(ovf[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on DUT d and check it to completion. Returns in the
    // done cycle so the caller may issue a back-to-back start.
    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input bit hold);
        logic [15:0] eb;
        logic [16:0] full;
        logic        ov;
        logic [15:0] prev;
        logic [17:0] exp;
        int          lat;
        eb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, eb} + {16'd0, (s ? 1'b1 : c)};
        ov   = (a[15] == eb[15]) && (full[15] != a[15]);
        sb_q.push_back({full[16], ov, full[15:0]});
        prev = sum[d];

        a_in = a; b_in = b; sub_in = s; cin_in = c;
        start[d] = 1'b1;
        step();
        if (!hold) start[d] = 1'b0;
        check("busy_after_accept", busy[d], 1);
        check("done_low_after_accept", done[d], 0);

        lat = 0;
        while (!done[d] && lat < 64) begin
            check("busy_during_op", busy[d], 1);
            check("sum_stable", sum[d], prev);
            if (hold) begin
                a_in = 16'($urandom); b_in = 16'($urandom);
                sub_in = 1'($urandom); cin_in = 1'($urandom);
            end
            step();
            lat++;
        end
        if (hold) start[d] = 1'b0;
        check("latency", lat, nchunks[d]);
        check("busy_low_at_done", busy[d], 0);

        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            exp = sb_q.pop_front();
            check("sum", sum[d], exp[15:0]);
            check("cout", cout[d], exp[17]);
            check("ovf", ovf[d], exp[16]);
        end
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;

        // Reset state on all three instances
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_sum", sum[d], 0);
            check("rst_cout", cout[d], 0);
            check("rst_ovf", ovf[d], 0);
        end

        // Cases 1-4 at every chunk size
        for (int d = 0; d < 3; d++) begin
            run_op(d, 16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b0);
            step(); check("done_one_cycle", done[d], 0);
            run_op(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
            step(); check("done_one_cycle", done[d], 0);
            run_op(d, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
            step(); check("done_one_cycle", done[d], 0);
            run_op(d, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
            step(); check("done_one_cycle", done[d], 0);
            run_op(d, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
            step(); check("done_one_cycle", done[d], 0);
        end

        // Start held high with changing operands: only the first op counts
        run_op(0, 16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("hold_no_extra_busy", busy[0], 0);
            check("hold_no_extra_done", done[0], 0);
        end

        // Back-to-back: second start issued in the done cycle
        run_op(0, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(); check("done_one_cycle", done[0], 0);

        // Asynchronous reset between E2 and E3 aborts the operation
        a_in = 16'h1111; b_in = 16'h2222; sub_in = 1'b0; cin_in = 1'b0;
        start[0] = 1'b1;
        step();                 // E0
        start[0] = 1'b0;
        step();                 // E1
        step();                 // E2
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_sum", sum[0], 0);
        check("abort_cout", cout[0], 0);
        check("abort_ovf", ovf[0], 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", done[0], 0);
            step();
        end
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        step();

        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
